// File: rtl/mac_stream_feeder.sv
// Per-job sequencer: clears the MAC accumulator, streams 256-bit source beats onto the four
// 64-bit DMA lanes, requests the biased result and holds it for a valid/ready consumer.
module mac_stream_feeder #(
    parameter int LEN_W   = 10,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] beat_count,
    input  logic [15:0]      bias_in,
    input  logic             op_mode_in,
    output logic             busy,
    input  logic             src_valid,
    output logic             src_ready,
    input  logic [255:0]     src_data,
    output logic [63:0]      DMA_channel_0,
    output logic [63:0]      DMA_channel_1,
    output logic [63:0]      DMA_channel_2,
    output logic [63:0]      DMA_channel_3,
    output logic [15:0]      bias,
    output logic             op_mode,
    output logic             en,
    output logic             clr,
    output logic             read_en,
    input  logic             done,
    input  logic [15:0]      result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [15:0]      res_data,
    output logic             timeout_err
);
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        READ   = 3'd4,
        WAIT   = 3'd5
    } state_t;

    state_t           state_r;
    logic [LEN_W-1:0] beats_left_r;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [63:0]      ch_r [0:3];
    logic [15:0]      bias_r;
    logic             op_mode_r;
    logic             en_r;
    logic             clr_r;
    logic             read_en_r;
    logic             res_valid_r;
    logic [15:0]      res_data_r;
    logic             timeout_err_r;
    logic             start_ok_s;

    // A held result blocks new jobs until the consumer has taken it.
    assign start_ok_s    = start && !res_valid_r;
    assign busy          = (state_r != IDLE);
    assign src_ready     = (state_r == STREAM);
    assign DMA_channel_0 = ch_r[0];
    assign DMA_channel_1 = ch_r[1];
    assign DMA_channel_2 = ch_r[2];
    assign DMA_channel_3 = ch_r[3];
    assign bias          = bias_r;
    assign op_mode       = op_mode_r;
    assign en            = en_r;
    assign clr           = clr_r;
    assign read_en       = read_en_r;
    assign res_valid     = res_valid_r;
    assign res_data      = res_data_r;
    assign timeout_err   = timeout_err_r;

    // Job sequencer with registered strobes, lane data and result holding register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            beats_left_r  <= '0;
            wait_cnt_r    <= '0;
            for (int k = 0; k < 4; k++) ch_r[k] <= 64'd0;
            bias_r        <= 16'd0;
            op_mode_r     <= 1'b0;
            en_r          <= 1'b0;
            clr_r         <= 1'b0;
            read_en_r     <= 1'b0;
            res_valid_r   <= 1'b0;
            res_data_r    <= 16'd0;
            timeout_err_r <= 1'b0;
        end else begin
            en_r      <= 1'b0;
            clr_r     <= 1'b0;
            read_en_r <= 1'b0;
            if (res_valid_r && res_ready) begin
                res_valid_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (start_ok_s) begin
                        beats_left_r  <= beat_count;
                        bias_r        <= bias_in;
                        op_mode_r     <= op_mode_in;
                        timeout_err_r <= 1'b0;
                        clr_r         <= 1'b1;
                        state_r       <= CLEAR;
                    end
                end
                CLEAR: begin
                    if (beats_left_r != '0) begin
                        state_r <= STREAM;
                    end else begin
                        read_en_r <= 1'b1;
                        state_r   <= READ;
                    end
                end
                STREAM: begin
                    if (src_valid) begin
                        for (int k = 0; k < 4; k++) ch_r[k] <= src_data[64*k +: 64];
                        en_r         <= 1'b1;
                        beats_left_r <= beats_left_r - LEN_W'(1);
                        if (beats_left_r == LEN_W'(1)) begin
                            state_r <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    read_en_r <= 1'b1;
                    state_r   <= READ;
                end
                READ: begin
                    wait_cnt_r <= CNT_W'(1);
                    state_r    <= WAIT;
                end
                WAIT: begin
                    // A done on the final allowed cycle still wins over the timeout.
                    if (done) begin
                        res_data_r  <= result;
                        res_valid_r <= 1'b1;
                        state_r     <= IDLE;
                    end else if (wait_cnt_r == CNT_W'(TIMEOUT)) begin
                        timeout_err_r <= 1'b1;
                        state_r       <= IDLE;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mac_stream_feeder.sv
// Self-checking bench for mac_stream_feeder: each job's expected strobe/lane/result timeline is
// derived from the driven valid pattern and the job timing rules, then compared cycle by cycle.
module tb_mac_stream_feeder;
    localparam int LEN_W = 10;
    localparam int TMO   = 8;
    localparam int MAXC  = 256;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] beat_count;
    logic [15:0]      bias_in;
    logic             op_mode_in;
    logic             busy;
    logic             src_valid;
    logic             src_ready;
    logic [255:0]     src_data;
    logic [63:0]      DMA_channel_0, DMA_channel_1, DMA_channel_2, DMA_channel_3;
    logic [15:0]      bias;
    logic             op_mode;
    logic             en, clr, read_en;
    logic             done;
    logic [15:0]      result;
    logic             res_valid;
    logic             res_ready;
    logic [15:0]      res_data;
    logic             timeout_err;

    int n_tests = 0;
    int n_fail  = 0;
    bit prev_to = 1'b0;

    mac_stream_feeder #(.LEN_W(LEN_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .beat_count(beat_count), .bias_in(bias_in),
        .op_mode_in(op_mode_in), .busy(busy), .src_valid(src_valid), .src_ready(src_ready),
        .src_data(src_data), .DMA_channel_0(DMA_channel_0), .DMA_channel_1(DMA_channel_1),
        .DMA_channel_2(DMA_channel_2), .DMA_channel_3(DMA_channel_3), .bias(bias),
        .op_mode(op_mode), .en(en), .clr(clr), .read_en(read_en), .done(done),
        .result(result), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] rand256();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One job: build the valid/data schedule, derive the expected timeline, drive and compare.
    task automatic run_job(input int len, input int vmode, input int ddly, input bit fixed_data,
                           input logic [15:0] resv, input logic [15:0] bs, input logic om,
                           input int hold);
        bit           v   [MAXC];
        logic [255:0] dat [MAXC];
        bit           bp  [7];
        int           hs[$];
        int           n, r, dcyc, endc, k, last_hs;
        bit           exp_en;
        logic [6:0]   exp_f, obs_f;
        logic [255:0] obs_ch;
        bp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        n = 0;
        for (int i = 0; i < MAXC; i++) begin
            if (vmode == 0)                 v[i] = 1'b1;
            else if (vmode == 1 && i >= 2)  v[i] = (i < 9) ? bp[i-2] : 1'b1;
            else                            v[i] = 1'($urandom_range(0, 1));
            dat[i] = fixed_data ? {4{64'(n + 1)}} : rand256();
            if (i >= 2 && v[i] && n < len) begin
                hs.push_back(i);
                n++;
            end
        end
        last_hs = (len > 0) ? hs[hs.size()-1] : -1;
        r       = (len > 0) ? last_hs + 2 : 2;
        dcyc    = (ddly > 0) ? r + ddly : -1;
        endc    = (ddly > 0) ? dcyc : r + TMO;
        k       = 0;
        for (int i = 0; i <= endc + 1; i++) begin
            @(posedge clk); #1;
            start      = (i == 0);
            beat_count = (i == 0) ? LEN_W'(len) : LEN_W'($urandom());
            bias_in    = (i == 0) ? bs : 16'($urandom());
            op_mode_in = (i == 0) ? om : 1'($urandom());
            src_valid  = v[i];
            src_data   = dat[i];
            done       = (i == dcyc) || (i <= r && $urandom_range(0, 3) == 0);
            result     = (i == dcyc) ? resv : 16'($urandom());
            res_ready  = 1'b0;
            @(negedge clk);
            exp_en = (k < hs.size()) && (hs[k] == i - 1);
            exp_f  = {(i >= 1 && i <= endc), (len > 0 && i >= 2 && i <= last_hs), exp_en,
                      (i == 1), (i == r), (ddly > 0 && i == endc + 1),
                      (i == 0) ? prev_to : (ddly <= 0 && i == endc + 1)};
            obs_f  = {busy, src_ready, en, clr, read_en, res_valid, timeout_err};
            n_tests++;
            if (obs_f !== exp_f) begin
                n_fail++;
                $display("FAIL flags len=%0d cyc=%0d busy/rdy/en/clr/rd/rv/to got=%b exp=%b",
                         len, i, obs_f, exp_f);
            end
            if (exp_en) begin
                obs_ch = {DMA_channel_3, DMA_channel_2, DMA_channel_1, DMA_channel_0};
                n_tests++;
                if (obs_ch !== dat[i-1]) begin
                    n_fail++;
                    $display("FAIL lanes beat=%0d cyc=%0d got=%h exp=%h", k, i, obs_ch, dat[i-1]);
                end
                k++;
            end
            if (i >= 1) begin
                n_tests++;
                if ({bias, op_mode} !== {bs, om}) begin
                    n_fail++;
                    $display("FAIL bias_mode cyc=%0d got=%h/%b exp=%h/%b", i, bias, op_mode, bs, om);
                end
            end
            if (ddly > 0 && i == endc + 1) begin
                n_tests++;
                if (res_data !== resv) begin
                    n_fail++;
                    $display("FAIL res_data got=%h exp=%h", res_data, resv);
                end
            end
        end
        prev_to = (ddly <= 0);
        if (ddly > 0) begin
            // Result must stay put while unconsumed; starts meanwhile are ignored.
            for (int j = 0; j < hold; j++) begin
                @(posedge clk); #1;
                start = 1'($urandom_range(0, 1));
                done  = 1'($urandom_range(0, 1));
                @(negedge clk);
                n_tests++;
                if ({res_valid, busy, clr, res_data} !== {1'b1, 1'b0, 1'b0, resv}) begin
                    n_fail++;
                    $display("FAIL res_hold j=%0d got rv=%b busy=%b clr=%b data=%h exp data=%h",
                             j, res_valid, busy, clr, res_data, resv);
                end
            end
            @(posedge clk); #1;
            start     = 1'b1;
            res_ready = 1'b1;
            done      = 1'b0;
            @(posedge clk); #1;
            start     = 1'b0;
            res_ready = 1'b0;
            @(negedge clk);
            n_tests++;
            if ({res_valid, busy, clr} !== 3'b000) begin
                n_fail++;
                $display("FAIL res_consume got rv/busy/clr=%b exp=000", {res_valid, busy, clr});
            end
        end
        start = 1'b0;
        done  = 1'b0;
    endtask

    task automatic test_reset();
        logic [295:0] all_out;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            rst        = 1'b1;
            start      = 1'($urandom());
            beat_count = LEN_W'($urandom());
            bias_in    = 16'($urandom());
            op_mode_in = 1'($urandom());
            src_valid  = 1'($urandom());
            src_data   = rand256();
            done       = 1'($urandom());
            result     = 16'($urandom());
            res_ready  = 1'($urandom());
            @(negedge clk);
            all_out = {busy, src_ready, DMA_channel_0, DMA_channel_1, DMA_channel_2, DMA_channel_3,
                       bias, op_mode, en, clr, read_en, res_valid, res_data, timeout_err};
            n_tests++;
            if (all_out !== '0) begin
                n_fail++;
                $display("FAIL reset cyc=%0d got=%h exp=0", c, all_out);
            end
        end
        @(posedge clk); #1;
        rst       = 1'b0;
        start     = 1'b0;
        done      = 1'b0;
        res_ready = 1'b0;
        prev_to   = 1'b0;
    endtask

    task automatic test_basic();
        run_job(3, 0, 2, 1'b1, 16'h1234, 16'($urandom()), 1'($urandom()), 2);
    endtask

    task automatic test_backpressure();
        run_job(4, 1, 3, 1'b0, 16'($urandom()), 16'($urandom()), 1'($urandom()), 1);
    endtask

    task automatic test_zero_len();
        run_job(0, 2, 1, 1'b0, 16'($urandom()), 16'h00A5, 1'b1, 0);
    endtask

    task automatic test_timeout();
        run_job(2, 2, 0, 1'b0, 16'h0000, 16'($urandom()), 1'b0, 0);
        run_job(1, 0, 1, 1'b0, 16'($urandom()), 16'($urandom()), 1'b1, 0);
    endtask

    task automatic test_done_window();
        run_job(1, 0, TMO, 1'b0, 16'($urandom()), 16'($urandom()), 1'b0, 1);
        run_job(2, 2, 1, 1'b0, 16'($urandom()), 16'($urandom()), 1'b1, 0);
    endtask

    task automatic test_back_to_back();
        for (int j = 0; j < 6; j++) begin
            run_job($urandom_range(0, 12), 2, $urandom_range(0, TMO), 1'b0, 16'($urandom()),
                    16'($urandom()), 1'($urandom()), $urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_midjob();
        logic [295:0] all_out;
        @(posedge clk); #1;
        start      = 1'b1;
        beat_count = LEN_W'(4);
        src_valid  = 1'b1;
        src_data   = rand256();
        done       = 1'b0;
        res_ready  = 1'b0;
        for (int c = 1; c < 4; c++) begin
            @(posedge clk); #1;
            start    = 1'b0;
            src_data = rand256();
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
        done   = 1'b1;
        result = 16'($urandom());
        @(negedge clk);
        all_out = {busy, src_ready, DMA_channel_0, DMA_channel_1, DMA_channel_2, DMA_channel_3,
                   bias, op_mode, en, clr, read_en, res_valid, res_data, timeout_err};
        n_tests++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL midjob_reset got=%h exp=0", all_out);
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            done = 1'b1;
            @(negedge clk);
            n_tests++;
            if ({busy, en, clr, read_en, res_valid, timeout_err} !== 6'b000000) begin
                n_fail++;
                $display("FAIL late_done cyc=%0d got=%b exp=000000", c,
                         {busy, en, clr, read_en, res_valid, timeout_err});
            end
        end
        done      = 1'b0;
        src_valid = 1'b0;
        prev_to   = 1'b0;
        run_job(1, 0, 2, 1'b0, 16'($urandom()), 16'($urandom()), 1'($urandom()), 1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; beat_count = '0; bias_in = 16'd0; op_mode_in = 1'b0;
        src_valid = 1'b0; src_data = '0; done = 1'b0; result = 16'd0; res_ready = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_timeout();
        test_done_window();
        test_back_to_back();
        test_reset_midjob();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_stream_feeder.md
# mac_stream_feeder

Sequencer that drives the DMA-side input interface of the MAC datapath. Per dot-product job it clears the accumulator, streams beats from a 256-bit source buffer onto the four 64-bit DMA channels, requests the biased result, and returns the 16-bit result through a valid/ready output. It sits between the on-chip operand buffer and the MAC/activation top level, and is the producer of the channel/control signals that the top level consumes.

## Interface
- LEN_W, 10, width of beat_count (max job length 2^LEN_W-1 beats)
- TIMEOUT, 255, max cycles to wait for done after read_en (≥1)

- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  job request; accepted only in IDLE with res_valid=0, else ignored
- beat_count  in  LEN_W  beats in job, sampled with accepted start
- bias_in  in  16  bias for job, sampled with accepted start
- op_mode_in  in  1  output mode for job, sampled with accepted start
- busy  out  1  job in progress
- src_valid  in  1  source beat available
- src_ready  out  1  feeder accepts beat
- src_data  in  256  lane k = src_data[64k+63:64k]
- DMA_channel_0..DMA_channel_3  out  64 each  registered lane data to MAC
- bias  out  16  latched bias_in
- op_mode  out  1  latched op_mode_in
- en  out  1  one-cycle strobe per valid channel beat
- clr  out  1  accumulator clear strobe
- read_en  out  1  result request strobe
- done  in  1  MAC result valid strobe
- result  in  16  MAC/activation result, valid with done
- res_valid  out  1  result held for consumer
- res_ready  in  1  consumer accepts result
- res_data  out  16  captured result
- timeout_err  out  1  sticky; set on timeout, cleared by next accepted start

## Operation
- States: IDLE, CLEAR, STREAM, DRAIN, READ, WAIT.
- IDLE: src_ready=0, strobes 0. Accepted start latches beat_count→beats_left, bias_in→bias, op_mode_in→op_mode; clears timeout_err; → CLEAR.
- CLEAR: clr=1 for one cycle; → STREAM if beats_left≠0, else → READ.
- STREAM: src_ready=1 (combinational from state). On src_valid&&src_ready: register four lanes onto DMA_channel_0..3, assert en next cycle, decrement beats_left; on last beat → DRAIN. No beat accepted → en=0 next cycle.
- DRAIN: one cycle; final en is high here. → READ.
- READ: read_en=1 one cycle; reset timeout counter; → WAIT.
- WAIT: on done: res_data←result, res_valid←1, → IDLE. Counter reaching TIMEOUT without done: timeout_err←1, → IDLE, res_valid stays 0.
- done outside WAIT ignored. res_valid cleared on res_valid&&res_ready; start blocked while res_valid=1.
- DMA_channel_* hold last value when en=0; bias/op_mode hold latched value until next accepted start.
- busy = (state≠IDLE).
- Beat count exact: number of en pulses per job equals beat_count.

## Timing
- Reset (rst high at edge): next cycle all outputs 0 (DMA_channel_*, bias, op_mode, res_data included), state IDLE, beats_left 0, res_valid 0, timeout_err 0. In-flight job aborted; no strobes follow.
- start accepted cycle T: busy and clr at T+1; src_ready from T+2.
- Beat accepted cycle t: DMA_channel_* and en valid at t+1 (1-cycle latency).
- Last beat accepted cycle tL: read_en at tL+2.
- beat_count=0: clr T+1, read_en T+2, no en.
- read_en at cycle r: done accepted in r+1..r+TIMEOUT; done at d → res_valid and res_data at d+1; busy low at d+1.
- No done by r+TIMEOUT: timeout_err=1 and busy=0 at r+TIMEOUT+1.
- start coincident with res_ready handshake: ignored (res_valid still 1 that cycle).

## Test plan
- Reset: drive rst 2 cycles with random inputs → every output 0, src_ready 0, busy 0.
- beat_count=3, src_valid constant 1, lanes 0x..01/02/03 per beat, start at T → clr T+1, en T+3..T+5 with matching lanes, read_en T+6; done at T+8 with result 0x1234 → res_valid=1, res_data=0x1234 at T+9, held until res_ready.
- Backpressure: beat_count=4, src_valid pattern 1,0,0,1,1,0,1 → exactly 4 en pulses, each one cycle after its handshake, lane data in order; read_en two cycles after 4th handshake.
- beat_count=0, bias_in=0x00A5, op_mode_in=1 → clr T+1, read_en T+2, no en, bias=0x00A5, op_mode=1 from T+1.
- TIMEOUT=8, done never asserted → timeout_err=1 and busy=0 at r+9, res_valid 0; next start clears timeout_err at T+1.
- rst asserted after 2 of 4 beats → next cycle all outputs 0; late done ignored; fresh job with beat_count=1 completes normally.
